// File: rtl/salu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : salu_pkg
// Description : Shared types for the scalar ALU and its requester arbiter:
//               ALU op codes, result flag bundle and response FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package salu_pkg;

    // ALU operation codes; forwarded to salu unmodified.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_BEQ  = 4'd10,
        ALU_BNE  = 4'd11,
        ALU_BLT  = 4'd12,
        ALU_BGE  = 4'd13,
        ALU_BLTU = 4'd14,
        ALU_BGEU = 4'd15
    } alu_op_e;

    // Result flags, packed as {overflow, negative, zero}.
    typedef struct packed {
        logic ovf;
        logic neg;
        logic zero;
    } alu_flags_t;

    // Response path state.
    typedef enum logic [1:0] {
        RESP_IDLE     = 2'd0,
        RESP_INFLIGHT = 2'd1,
        RESP_HOLD     = 2'd2
    } resp_state_e;

endpackage : salu_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Returns the first asserted
//               request at or after the pointer position (wrapping).
// Ports       : req   - request vector
//               en    - allow a grant this cycle
//               ptr   - highest-priority index (must be < NUM_REQ)
//               grant - one-hot grant (zero when none)
//               idx   - index of granted request
//               valid - a grant was made
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    int k;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Walk from ptr upward, wrapping once past the top.
            k = int'(ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (en && !valid && req[k]) begin
                valid    = 1'b1;
                grant[k] = 1'b1;
                idx      = ID_W'(k);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/salu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : salu_arbiter
// Description : Shares one registered scalar ALU (1-cycle latency) between
//               NUM_REQ requesters. Round-robin issue, valid/ready request
//               and response handshakes, one-entry hold buffer for response
//               backpressure, synchronous flush.
// Ports       : clk, rst_n (async, active-low), flush_i
//               req_valid_i/req_ready_o/req_op_i/req_rs1_i/req_rs2_i
//               resp_valid_o/resp_ready_i/resp_data_o/resp_flags_o
//               alu_rs1_o/alu_rs2_o/alu_op_o  -> salu
//               alu_res_i/alu_zero_i/alu_neg_i/alu_ovf_i <- salu
//               busy_o - response path not idle
// Revision    : 1.0 - initial release
// ============================================================================
module salu_arbiter
    import salu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*4-1:0]          req_op_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rs1_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rs2_i,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    input  logic [NUM_REQ-1:0]            resp_ready_i,
    output logic [DATA_WIDTH-1:0]         resp_data_o,
    output logic [2:0]                    resp_flags_o,
    output logic [DATA_WIDTH-1:0]         alu_rs1_o,
    output logic [DATA_WIDTH-1:0]         alu_rs2_o,
    output logic [3:0]                    alu_op_o,
    input  logic [DATA_WIDTH-1:0]         alu_res_i,
    input  logic                          alu_zero_i,
    input  logic                          alu_neg_i,
    input  logic                          alu_ovf_i,
    output logic                          busy_o
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    resp_state_e            state_q, state_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
    alu_flags_t             hold_flags_q, hold_flags_d;

    logic                   w_owner_ready;
    logic                   w_issue_en;
    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_grant_idx;
    logic                   w_grant_valid;
    alu_flags_t             w_alu_flags;

    assign w_alu_flags   = '{ovf: alu_ovf_i, neg: alu_neg_i, zero: alu_zero_i};
    assign w_owner_ready = resp_ready_i[owner_q];

    // rst_n gates issue so nothing is granted while reset is held low.
    assign w_issue_en = rst_n && !flush_i &&
                        ((state_q == RESP_IDLE) || w_owner_ready);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req   (req_valid_i),
        .en    (w_issue_en),
        .ptr   (rr_ptr_q),
        .grant (w_grant),
        .idx   (w_grant_idx),
        .valid (w_grant_valid)
    );

    assign req_ready_o = w_grant;
    assign busy_o      = (state_q != RESP_IDLE);

    // ALU operand/op mux; idle slots issue ADD 0,0.
    always_comb begin
        alu_op_o  = ALU_ADD;
        alu_rs1_o = '0;
        alu_rs2_o = '0;
        if (w_grant_valid) begin
            alu_op_o  = req_op_i[w_grant_idx*4 +: 4];
            alu_rs1_o = req_rs1_i[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
            alu_rs2_o = req_rs2_i[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Response outputs: live ALU outputs while in flight, hold regs otherwise.
    always_comb begin
        resp_valid_o = '0;
        if ((state_q != RESP_IDLE) && !flush_i) begin
            resp_valid_o[owner_q] = 1'b1;
        end
        if (state_q == RESP_INFLIGHT) begin
            resp_data_o  = alu_res_i;
            resp_flags_o = w_alu_flags;
        end else begin
            resp_data_o  = hold_data_q;
            resp_flags_o = hold_flags_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        hold_data_d  = hold_data_q;
        hold_flags_d = hold_flags_q;

        if (flush_i) begin
            state_d      = RESP_IDLE;
            hold_data_d  = '0;
            hold_flags_d = '0;
        end else begin
            case (state_q)
                RESP_INFLIGHT: begin
                    if (!w_owner_ready) begin
                        // Capture the one-cycle ALU result before it is lost.
                        state_d      = RESP_HOLD;
                        hold_data_d  = alu_res_i;
                        hold_flags_d = w_alu_flags;
                    end else begin
                        state_d = RESP_IDLE;
                    end
                end
                RESP_HOLD: begin
                    if (w_owner_ready) begin
                        state_d = RESP_IDLE;
                    end
                end
                default: begin
                    state_d = RESP_IDLE;
                end
            endcase

            // A grant overrides the drain target: back-to-back issue.
            if (w_grant_valid) begin
                state_d = RESP_INFLIGHT;
                owner_d = w_grant_idx;
                if (int'(w_grant_idx) == NUM_REQ - 1) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = w_grant_idx + ID_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESP_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            hold_data_q  <= '0;
            hold_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_data_q  <= hold_data_d;
            hold_flags_q <= hold_flags_d;
        end
    end

endmodule : salu_arbiter
`default_nettype wire
